serial_adder: RTL

Bit-serial, parametrised N-bit adder/subtractor built from one full-adder cell (XOR/AND sum/carry logic) and a carry flip-flop. It is the multi-bit, sequential generalisation of the team's half/full adder cells. It processes one bit per clock, LSB first, and uses a start/busy/done handshake. It trades latency for area and is intended as the arithmetic unit for small datapath experiments.

---
 rtl/serial_adder_if.sv | 25 ++
 rtl/serial_adder.sv | 99 +++++++++
 2 files changed

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: start/busy/done handshake plus operands and results.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder/subtractor: one full-adder cell plus a carry flop, one bit per clock, LSB first.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic             carry;
    logic [CW-1:0]    bit_cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic             bit_sum;
    logic             carry_next;
    logic [WIDTH-1:0] res_next;

    assign bit_sum    = a_sr[0] ^ b_sr[0] ^ carry;
    assign carry_next = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign res_next   = {bit_sum, res_sr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
                        a_sr    <= bus.a;
                        b_sr    <= bus.sub ? ~bus.b : bus.b;
                        carry   <= bus.sub ? 1'b1 : bus.cin;
                        bit_cnt <= '0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    res_sr  <= res_next[WIDTH-1:1];
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    carry   <= carry_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        // On the MSB edge, carry is the carry into the MSB, so ovf needs no extra flop.
                        sum_q  <= res_next;
                        cout_q <= carry_next;
                        ovf_q  <= carry ^ carry_next;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule
